// File: rtl/counter_monitor_pkg.sv
// Shared codes, widths and the event record for the counter monitor.
// Mode and tag encodings live only here; every other file imports them.
package counter_monitor_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned TAG_W  = 2;
    localparam int unsigned MODE_W = 2;
    localparam int unsigned CNT_W  = 16;

    localparam logic ALTO = 1'b1;
    localparam logic BAJO = 1'b0;

    typedef enum logic [MODE_W-1:0] {
        MODO_INC  = 2'b00,
        MODO_DEC  = 2'b01,
        MODO_INC3 = 2'b10,
        MODO_LOAD = 2'b11
    } modo_e;

    typedef enum logic [TAG_W-1:0] {
        TAG_RCO  = 2'b00,
        TAG_LOAD = 2'b01,
        TAG_MODO = 2'b10,
        TAG_STEP = 2'b11
    } tag_e;

    typedef struct packed {
        tag_e              tag;
        logic [DATA_W-1:0] data;
    } ev_entry_t;

    localparam int unsigned EV_W = $bits(ev_entry_t);

    // Counter increment for a counting mode; a load has no predictable step.
    function automatic logic [DATA_W-1:0] step_delta(input modo_e m);
        logic [DATA_W-1:0] d;
        case (m)
            MODO_INC:  d = DATA_W'(1);
            MODO_DEC:  d = '1;
            MODO_INC3: d = DATA_W'(3);
            default:   d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/counter_monitor_if.sv
// Event stream head: the monitor drives valid/tag/data, the consumer drives ready.
interface counter_monitor_if;
    import counter_monitor_pkg::*;

    logic              EV_VALID;
    logic              EV_READY;
    logic [TAG_W-1:0]  EV_TAG;
    logic [DATA_W-1:0] EV_DATA;

    modport master (
        output EV_VALID,
        output EV_TAG,
        output EV_DATA,
        input  EV_READY
    );

    modport slave (
        input  EV_VALID,
        input  EV_TAG,
        input  EV_DATA,
        output EV_READY
    );

endinterface

// File: rtl/counter_monitor_fifo.sv
// Synchronous FIFO for monitor events; head is shown from registers, zero when empty.
// A push into a full FIFO is accepted only when a pop happens at the same edge.
module monitor_fifo #(
    parameter int unsigned WIDTH = 34,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; the empty flag masks stale contents.
    always_ff @(posedge clk_i) begin
        if (!rst_i && do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/counter_monitor.sv
// Watches a 32-bit counter's controls and output, flags bad steps and
// queues tagged events (step error, load, rollover, mode change) for a consumer.
module counter_monitor
    import counter_monitor_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              ENABLE,
    input  logic [MODE_W-1:0] MODO,
    input  logic [DATA_W-1:0] Q,
    input  logic              RCO,
    input  logic              LOAD,
    counter_monitor_if.master ev,
    output logic [CNT_W-1:0]  RCO_COUNT,
    output logic              STEP_ERR,
    output logic              DROPPED
);

    modo_e             cur_modo;
    logic [DATA_W-1:0] prev_q_q;
    modo_e             prev_modo_q;
    logic              prev_en_q;
    logic              prev_valid_q;
    logic              prev_rco_q;
    logic              prev_load_q;

    logic [CNT_W-1:0]  rco_count_q, rco_count_d;
    logic              step_err_q, step_err_d;
    logic              dropped_q, dropped_d;

    logic [DATA_W-1:0] exp_q_c;
    logic              step_err_c, load_rise_c, rco_rise_c, modo_chg_c;
    logic              any_ev_c, multi_ev_c;
    logic [2:0]        n_ev_c;
    ev_entry_t         ev_entry_c;
    ev_entry_t         head;
    logic              fifo_full, fifo_empty;
    logic              push_c, pop_c, drop_c;

    assign cur_modo = modo_e'(MODO);
    assign exp_q_c  = prev_q_q + step_delta(prev_modo_q);

    // Q seen now is the counter's answer to the controls seen one edge ago.
    always_comb begin
        step_err_c = BAJO;
        if (prev_valid_q) begin
            if (!prev_en_q) begin
                step_err_c = (Q != prev_q_q);
            end else if (prev_modo_q != MODO_LOAD && cur_modo == prev_modo_q) begin
                step_err_c = (Q != exp_q_c);
            end
        end
    end

    assign load_rise_c = prev_valid_q && LOAD && !prev_load_q;
    assign rco_rise_c  = prev_valid_q && RCO && !prev_rco_q;
    assign modo_chg_c  = prev_valid_q && (cur_modo != prev_modo_q);

    assign n_ev_c     = 3'(step_err_c) + 3'(load_rise_c) + 3'(rco_rise_c) + 3'(modo_chg_c);
    assign any_ev_c   = (n_ev_c != '0);
    assign multi_ev_c = (n_ev_c > 3'(1));

    // One write per cycle: step error, then load, then rollover, then mode change.
    always_comb begin
        ev_entry_c = '0;
        if (step_err_c) begin
            ev_entry_c = '{tag: TAG_STEP, data: Q};
        end else if (load_rise_c) begin
            ev_entry_c = '{tag: TAG_LOAD, data: Q};
        end else if (rco_rise_c) begin
            ev_entry_c = '{tag: TAG_RCO, data: Q};
        end else if (modo_chg_c) begin
            ev_entry_c = '{tag: TAG_MODO, data: DATA_W'(MODO)};
        end
    end

    assign pop_c  = !fifo_empty && ev.EV_READY;
    assign push_c = any_ev_c && (!fifo_full || pop_c);
    assign drop_c = multi_ev_c || (any_ev_c && !push_c);

    always_comb begin
        rco_count_d = rco_count_q;
        step_err_d  = step_err_q;
        dropped_d   = dropped_q;
        if (rco_rise_c && (rco_count_q != '1)) begin
            rco_count_d = rco_count_q + CNT_W'(1);
        end
        if (step_err_c) begin
            step_err_d = ALTO;
        end
        if (drop_c) begin
            dropped_d = ALTO;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            prev_q_q     <= '0;
            prev_modo_q  <= MODO_INC;
            prev_en_q    <= BAJO;
            prev_valid_q <= BAJO;
            prev_rco_q   <= BAJO;
            prev_load_q  <= BAJO;
            rco_count_q  <= '0;
            step_err_q   <= BAJO;
            dropped_q    <= BAJO;
        end else begin
            prev_q_q     <= Q;
            prev_modo_q  <= cur_modo;
            prev_en_q    <= ENABLE;
            prev_valid_q <= ALTO;
            prev_rco_q   <= RCO;
            prev_load_q  <= LOAD;
            rco_count_q  <= rco_count_d;
            step_err_q   <= step_err_d;
            dropped_q    <= dropped_d;
        end
    end

    monitor_fifo #(
        .WIDTH (EV_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_i   (RESET),
        .push_i  (push_c),
        .pop_i   (pop_c),
        .wdata_i (ev_entry_c),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign ev.EV_VALID = !fifo_empty;
    assign ev.EV_TAG   = head.tag;
    assign ev.EV_DATA  = head.data;

    assign RCO_COUNT = rco_count_q;
    assign STEP_ERR  = step_err_q;
    assign DROPPED   = dropped_q;

endmodule

// File: tb/tb_counter_monitor.sv
// Bench for counter_monitor: directed scenarios plus random traffic, with a
// rule-level reference model feeding a scoreboard that a monitor drains.
module tb_counter_monitor;

    localparam int DEPTH = 4;

    typedef struct {
        logic [1:0]  tag;
        logic [31:0] data;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic [1:0]  modo = 2'b00;
    logic [31:0] q = 32'd0;
    logic        rco = 1'b0;
    logic        load = 1'b0;
    logic        rdy = 1'b0;
    logic [15:0] rco_count;
    logic        step_err;
    logic        dropped;

    counter_monitor_if ev_if ();
    assign ev_if.EV_READY = rdy;

    counter_monitor #(.FIFO_DEPTH(DEPTH)) dut (
        .CLK       (clk),
        .RESET     (rst),
        .ENABLE    (en),
        .MODO      (modo),
        .Q         (q),
        .RCO       (rco),
        .LOAD      (load),
        .ev        (ev_if),
        .RCO_COUNT (rco_count),
        .STEP_ERR  (step_err),
        .DROPPED   (dropped)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    bit mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Reference model: events derived from the observation rules, FIFO as an occupancy count.
    ev_t         sb_q[$];
    ev_t         cand[$];
    int          m_occ  = 0;
    int          m_rco  = 0;
    bit          m_step = 0;
    bit          m_drop = 0;
    bit          h_valid = 0, h_en = 0, h_rco = 0, h_load = 0;
    logic [1:0]  h_modo = 2'b00;
    logic [31:0] h_q = 32'd0;

    function automatic logic [31:0] advance(input logic [31:0] v, input logic [1:0] m);
        int d;
        d = (m == 2'd0) ? 1 : (m == 2'd1) ? -1 : 3;
        return v + 32'(d);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            sb_q.delete();
            m_occ = 0; m_rco = 0; m_step = 0; m_drop = 0;
            h_valid = 0; h_en = 0; h_rco = 0; h_load = 0; h_modo = 2'b00; h_q = 32'd0;
        end else begin
            bit pop;
            bit bad;
            cand.delete();
            pop = (m_occ > 0) && rdy;
            if (h_valid) begin
                bad = 0;
                if (!h_en) bad = (q != h_q);
                else if (h_modo != 2'b11 && modo == h_modo) bad = (q != advance(h_q, h_modo));
                if (bad) begin
                    cand.push_back('{2'b11, q});
                    m_step = 1;
                end
                if (load && !h_load) cand.push_back('{2'b01, q});
                if (rco && !h_rco) begin
                    cand.push_back('{2'b00, q});
                    if (m_rco < 16'hFFFF) m_rco++;
                end
                if (modo != h_modo) cand.push_back('{2'b10, {30'd0, modo}});
            end
            if (cand.size() > 1) m_drop = 1;
            if (cand.size() > 0) begin
                if (m_occ < DEPTH || pop) begin
                    sb_q.push_back(cand[0]);
                    m_occ++;
                end else begin
                    m_drop = 1;
                end
            end
            if (pop) m_occ--;
            h_valid = 1; h_en = en; h_modo = modo; h_q = q; h_rco = rco; h_load = load;
        end
    end

    // Monitor: mid-cycle compare of flags and the presented head against the scoreboard.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("ev_valid", 32'(ev_if.EV_VALID), 32'(m_occ != 0));
            chk("rco_count", 32'(rco_count), 32'(m_rco));
            chk("step_err", 32'(step_err), 32'(m_step));
            chk("dropped", 32'(dropped), 32'(m_drop));
            if (ev_if.EV_VALID) begin
                if (sb_q.size() == 0) begin
                    chk("ev_unexpected", 32'(1), 32'(0));
                end else begin
                    chk("ev_tag", 32'(ev_if.EV_TAG), 32'(sb_q[0].tag));
                    chk("ev_data", ev_if.EV_DATA, sb_q[0].data);
                    if (rdy) void'(sb_q.pop_front());
                end
            end
        end
    end

    // Counter stand-in: Q shown this cycle, then advanced by this cycle's controls.
    logic [31:0] cur_q = 32'd0;
    logic [31:0] load_val = 32'd0;

    task automatic tick(input logic e, input logic [1:0] m, input logic r, input logic l, input logic rd);
        en = e; modo = m; q = cur_q; rco = r; load = l; rdy = rd;
        if (e) cur_q = (m == 2'b11) ? load_val : advance(cur_q, m);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
    endtask

    task automatic drain(output int n);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (!ev_if.EV_VALID) break;
            n++;
            tick(en, modo, 1'b0, 1'b0, 1'b1);
        end
    endtask

    initial begin
        int n;
        @(posedge clk);
        #1;
        do_reset();
        chk("rst_ev_valid", 32'(ev_if.EV_VALID), 32'd0);
        chk("rst_ev_tag", 32'(ev_if.EV_TAG), 32'd0);
        chk("rst_ev_data", ev_if.EV_DATA, 32'd0);
        chk("rst_rco_count", 32'(rco_count), 32'd0);
        chk("rst_step_err", 32'(step_err), 32'd0);
        chk("rst_dropped", 32'(dropped), 32'd0);
        mon_en = 1'b1;

        // Clean +1 counting
        cur_q = 32'h0000_0005;
        for (int i = 0; i < 10; i++) tick(1'b1, 2'b00, 1'b0, 1'b0, 1'b1);
        chk("inc_no_event", 32'(ev_if.EV_VALID), 32'd0);
        chk("inc_step_err", 32'(step_err), 32'd0);

        // +3 across the 32-bit wrap, then a forced bad value
        cur_q = 32'hFFFF_FFFE;
        tick(1'b1, 2'b10, 1'b0, 1'b0, 1'b1);
        tick(1'b1, 2'b10, 1'b0, 1'b0, 1'b1);
        cur_q = 32'h0000_0005;
        tick(1'b1, 2'b10, 1'b0, 1'b0, 1'b1);
        chk("wrap_step_err", 32'(step_err), 32'd1);
        chk("wrap_err_tag", 32'(ev_if.EV_TAG), 32'd3);
        chk("wrap_err_data", ev_if.EV_DATA, 32'h0000_0005);
        for (int i = 0; i < 3; i++) tick(1'b1, 2'b10, 1'b0, 1'b0, 1'b1);

        // Five rollovers into a depth-4 FIFO with no consumer
        do_reset();
        tick(1'b1, 2'b00, 1'b0, 1'b0, 1'b1);
        tick(1'b1, 2'b00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 2'b00, 1'b1, 1'b0, 1'b0);
            tick(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        end
        chk("full_rco_count", 32'(rco_count), 32'd5);
        chk("full_dropped", 32'(dropped), 32'd1);
        chk("full_head_tag", 32'(ev_if.EV_TAG), 32'd0);
        drain(n);
        chk("full_drain_count", 32'(n), 32'd4);

        // Load and rollover rising together
        do_reset();
        tick(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        load_val = 32'h1234_5678;
        tick(1'b1, 2'b11, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 2'b11, 1'b1, 1'b1, 1'b1);
        chk("coll_tag", 32'(ev_if.EV_TAG), 32'd1);
        chk("coll_data", ev_if.EV_DATA, 32'h1234_5678);
        chk("coll_dropped", 32'(dropped), 32'd1);
        chk("coll_rco_count", 32'(rco_count), 32'd1);
        for (int i = 0; i < 3; i++) tick(1'b0, 2'b11, 1'b0, 1'b0, 1'b1);

        // Push into a full FIFO while it pops
        do_reset();
        tick(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, 2'b00, 1'b1, 1'b0, 1'b0);
            tick(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        end
        tick(1'b1, 2'b00, 1'b0, 1'b1, 1'b1);
        chk("pp_dropped", 32'(dropped), 32'd0);
        drain(n);
        chk("pp_drain_count", 32'(n), 32'd4);

        // Reset with events pending
        do_reset();
        tick(1'b1, 2'b00, 1'b0, 1'b0, 1'b1);
        tick(1'b1, 2'b00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) begin
            tick(1'b1, 2'b00, 1'b1, 1'b0, (i < 4) ? 1'b1 : 1'b0);
            tick(1'b1, 2'b00, 1'b0, 1'b0, (i < 4) ? 1'b1 : 1'b0);
        end
        chk("pre_rst_rco_count", 32'(rco_count), 32'd7);
        chk("pre_rst_valid", 32'(ev_if.EV_VALID), 32'd1);
        rst = 1'b1;
        tick(1'b1, 2'b01, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        chk("post_rst_valid", 32'(ev_if.EV_VALID), 32'd0);
        chk("post_rst_rco_count", 32'(rco_count), 32'd0);
        cur_q = 32'hDEAD_BEEF;
        tick(1'b1, 2'b10, 1'b1, 1'b1, 1'b1);
        chk("first_cycle_valid", 32'(ev_if.EV_VALID), 32'd0);
        chk("first_cycle_step_err", 32'(step_err), 32'd0);

        // Random traffic
        for (int i = 0; i < 800; i++) begin
            logic [1:0] m;
            m = ($urandom_range(0, 99) < 80) ? modo : 2'($urandom_range(0, 3));
            load_val = $urandom;
            if ($urandom_range(0, 99) < 3) cur_q = $urandom;
            if ($urandom_range(0, 99) < 2) cur_q = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
            rst = ($urandom_range(0, 199) == 0);
            tick(1'($urandom_range(0, 3) != 0), m,
                 1'($urandom_range(0, 99) < 25), 1'($urandom_range(0, 99) < 15),
                 1'($urandom_range(0, 99) < 60));
            rst = 1'b0;
        end
        for (int i = 0; i < 10; i++) tick(en, modo, 1'b0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/counter_monitor.md
COUNTER_MONITOR -- requirements
Module: counter_monitor

Interface
REQ-001 The module SHALL have one parameter: FIFO_DEPTH, default 4, event FIFO entries (power of two, 2..16).
REQ-002 The module SHALL have port CLK, input, 1, single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port RESET, input, 1, synchronous, active-high reset.
REQ-004 The module SHALL have port ENABLE, input, 1, counter enable as driven to the 32-bit counter.
REQ-005 The module SHALL have port MODO, input, 2, counter mode as driven to the counter (00 +1, 01 -1, 10 +3, 11 load D).
REQ-006 The module SHALL have port Q, input, 32, counter output value.
REQ-007 The module SHALL have ports RCO and LOAD, input, 1 each, counter rollover pulse and load indication.
REQ-008 The module SHALL have ports EV_VALID (output, 1), EV_READY (input, 1), EV_TAG (output, 2) and EV_DATA (output, 32), forming the event stream head.
REQ-009 The module SHALL have ports RCO_COUNT (output, 16), STEP_ERR (output, 1) and DROPPED (output, 1).

Function
REQ-010 Q sampled at edge t SHALL be treated as the result of ENABLE/MODO sampled at edge t-1.
REQ-011 The module SHALL register prev_q, prev_modo, prev_en and prev_valid every cycle; prev_valid SHALL go to 1 on the first cycle after reset.
REQ-012 A step check SHALL fire when prev_valid=1, prev_en=1, prev_modo!=11, MODO==prev_modo and Q != prev_q+delta, with delta +1/-1/+3 modulo 2^32 (32-bit wrap, e.g. 0xFFFFFFFF+1=0, 0-1=0xFFFFFFFF, 0xFFFFFFFE+3=1).
REQ-013 When prev_en=0, the module SHALL require Q==prev_q; a mismatch SHALL also be a step error.
REQ-014 An event SHALL be generated for: step error (tag 11, data Q), LOAD rising edge (tag 01, data Q), RCO rising edge (tag 00, data Q), and MODO change while prev_valid=1 (tag 10, data zero-extended new MODO).
REQ-015 At most one event SHALL be written per cycle, priority 11 > 01 > 00 > 10; losing simultaneous events SHALL set DROPPED.
REQ-016 An event arriving with the FIFO full SHALL be discarded and SHALL set DROPPED; FIFO contents SHALL be unchanged.
REQ-017 DROPPED and STEP_ERR SHALL be sticky until RESET.
REQ-018 RCO_COUNT SHALL increment on every RCO rising edge, irrespective of FIFO state, and SHALL saturate at 0xFFFF.
REQ-019 EV_VALID SHALL be high exactly when the FIFO is non-empty; EV_TAG/EV_DATA SHALL show the oldest entry and remain stable while EV_VALID=1 and EV_READY=0.
REQ-020 An entry SHALL be popped at an edge where EV_VALID=1 and EV_READY=1.
REQ-021 With the FIFO full, a simultaneous pop and push SHALL both complete and the event SHALL not be dropped; with the FIFO empty, a push SHALL be visible on EV_VALID one cycle later (no bypass).
REQ-022 Push-to-EV_VALID latency SHALL be 1 cycle; event detection SHALL add no further latency beyond REQ-010 sampling.

Reset
REQ-023 RESET=1 at an edge SHALL clear the FIFO (EV_VALID=0), RCO_COUNT=0, STEP_ERR=0, DROPPED=0, prev_valid=0, prev_q=0, and EV_TAG=00/EV_DATA=0.
REQ-024 RESET asserted mid-operation SHALL discard all pending events, and no events or checks SHALL be generated during the cycle after reset release.

Structure
REQ-025 Mode codes (00/01/10/11), event tag codes and ALTO/BAJO SHALL come from the shared defines file; no local literals.
REQ-026 The FIFO SHALL be one sub-module, monitor_fifo (width 34, depth FIFO_DEPTH, push/pop/full/empty); detection and checking SHALL stay in counter_monitor.

Verification
REQ-027 Scenario: reset, MODO=00, ENABLE=1, Q from 0x00000005 stepping +1 for 10 cycles, EV_READY=1 -> no events, STEP_ERR=0.
REQ-028 Scenario: MODO=10, Q sequence 0xFFFFFFFE, 0x00000001, then a forced 0x00000005 -> one tag-11 event with data 0x00000005, STEP_ERR=1.
REQ-029 Scenario: EV_READY=0, five RCO pulses with FIFO_DEPTH=4 -> four tag-00 entries, DROPPED=1, RCO_COUNT=5; then EV_READY=1 -> four pops in order.
REQ-030 Scenario: LOAD and RCO rising in the same cycle with Q=0x12345678 -> single tag-01 event with data 0x12345678, DROPPED=1, RCO_COUNT increments.
REQ-031 Scenario: FIFO full, EV_READY=1 and a new LOAD event at the same edge -> occupancy stays 4, DROPPED stays 0.
REQ-032 Scenario: RESET pulsed with 3 pending events and RCO_COUNT=7 -> EV_VALID=0 and RCO_COUNT=0 next cycle, no event in the first post-reset cycle.
